deadlock_report_arbiter: RTL and testbench
==========================================

DEADLOCK_REPORT_ARBITER -- requirements
Module: deadlock_report_arbiter

Interface
REQ-001 SHALL have parameter N_MON, default 4, number of deadlock monitors served (2..16).
REQ-002 SHALL have parameter CNT_W, default 16, persistence counter width.
REQ-003 SHALL have parameter PERSIST, default 1000, cycles a block flag must hold before reporting (1..2^CNT_W-1).
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mon_block  in  N_MON  per-monitor block flag, level, from per-process deadlock monitors.
REQ-007 clear  in  1  synchronous single-cycle flush of all state.
REQ-008 rpt_valid  out  1  report available.
REQ-009 rpt_ready  in  1  report sink accepts.
REQ-010 rpt_idx  out  clog2(N_MON)  index of reported monitor.
REQ-011 rpt_cycles  out  CNT_W  persistence count of that monitor at grant.
REQ-012 deadlock  out  1  sticky: any monitor has reached PERSIST since reset/clear.

Function
REQ-013 Per monitor i: cnt[i] SHALL increment each cycle mon_block[i]=1, saturate at 2^CNT_W-1, and load 0 on any cycle mon_block[i]=0.
REQ-014 pending[i] SHALL set on the cycle cnt[i] transitions from PERSIST-1 to PERSIST (one event per continuous block episode); re-arming requires cnt[i] to return to 0.
REQ-015 deadlock SHALL set on the same edge pending[i] sets, for any i, and hold until clear/reset.
REQ-016 FSM states: IDLE, PRESENT.
REQ-017 IDLE: if any pending bit set, SHALL grant the first set index at or after rr_ptr (wrapping N_MON-1 -> 0), register rpt_idx and rpt_cycles=cnt[grant], go to PRESENT; rpt_valid high the following cycle.
REQ-018 PRESENT: rpt_valid=1; rpt_idx, rpt_cycles SHALL remain stable until handshake.
REQ-019 Handshake (rpt_valid & rpt_ready) SHALL clear pending[rpt_idx], set rr_ptr = rpt_idx+1 modulo N_MON, return to IDLE; rpt_valid low next cycle.
REQ-020 Minimum report spacing SHALL be 2 cycles (IDLE visit mandatory).
REQ-021 If pending[j] sets in the same cycle pending[rpt_idx] is cleared by handshake, both SHALL take effect; j is not lost.
REQ-022 If pending sets for the currently presented index (new episode) on the handshake cycle, the set SHALL win; that index reports again.
REQ-023 clear SHALL zero cnt, pending, deadlock, rr_ptr and force IDLE next cycle, overriding handshake and new events in that cycle; rpt_valid may drop without handshake.
REQ-024 Monitor deasserting block after pending set SHALL NOT retract pending.

Reset
REQ-025 On reset: rpt_valid=0, rpt_idx=0, rpt_cycles=0, deadlock=0, cnt=0, pending=0, rr_ptr=0, state=IDLE.
REQ-026 Reset release SHALL be safe mid-PRESENT; no report is re-issued for pre-reset events.

Structure
REQ-027 Shared package SHALL hold FSM state enum and default parameter constants (N_MON, CNT_W, PERSIST).
REQ-028 Per-monitor saturating counter with PERSIST-crossing pulse SHALL be sub-module deadlock_persist_cnt, instantiated N_MON times; arbiter and FSM inline.

Verification (bench: N_MON=4, CNT_W=8, PERSIST=8)
REQ-029 mon_block[2]=1 for 20 cycles, rpt_ready=1 -> one report, rpt_idx=2, rpt_cycles=8, deadlock=1, rpt_valid 1 cycle after crossing.
REQ-030 mon_block=4'b1011 asserted same cycle, rpt_ready=1 -> reports idx 0,1,3 in order, each separated by an IDLE cycle.
REQ-031 rpt_ready=0 for 10 cycles while presenting idx 1 -> rpt_valid, rpt_idx, rpt_cycles constant; accepted on first ready cycle.
REQ-032 mon_block[0] high 300 cycles -> cnt saturates 255, single report; drop 1 cycle, reassert 8 cycles -> second report idx 0.
REQ-033 clear pulsed during PRESENT with pending={1,3} -> next cycle rpt_valid=0, deadlock=0, no further reports until new episode.
REQ-034 reset asserted mid-PRESENT (asynchronous, mid-cycle) -> outputs zero immediately; after release no report without new 8-cycle block.

Source files
------------

// File: rtl/deadlock_report_arbiter_pkg.sv
// Shared types and default sizing for the deadlock report arbiter.
package deadlock_report_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int DEF_N_MON   = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_PERSIST = 1000;

endpackage

// File: rtl/deadlock_persist_cnt.sv
// Per-monitor saturating persistence counter with a single pulse when the
// count crosses PERSIST within one continuous block episode.
module deadlock_persist_cnt
  import deadlock_report_arbiter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PERSIST = DEF_PERSIST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             block,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // The crossing is seen one edge early so pending sets on the same edge cnt reaches PERSIST.
  assign hit = block && (cnt == CNT_W'(PERSIST - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (block) cnt <= sat_inc(cnt);
    else            cnt <= '0;
  end

endmodule

// File: rtl/deadlock_report_arbiter.sv
// Collects persistent deadlock flags from N_MON monitors and presents them one
// at a time over a valid/ready report port with round-robin fairness.
module deadlock_report_arbiter
  import deadlock_report_arbiter_pkg::*;
#(
  parameter int N_MON   = DEF_N_MON,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PERSIST = DEF_PERSIST,
  localparam int IDX_W  = $clog2(N_MON)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_MON-1:0] mon_block,
  input  logic             clear,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_idx,
  output logic [CNT_W-1:0] rpt_cycles,
  output logic             deadlock
);

  logic [CNT_W-1:0] cnt [N_MON];
  logic [N_MON-1:0] hit;
  logic [N_MON-1:0] pending;
  logic [N_MON-1:0] clr_mask;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   scan;
  logic             gnt_found;
  logic             handshake;
  state_t           state, state_next;

  for (genvar i = 0; i < N_MON; i++) begin : g_mon
    deadlock_persist_cnt #(
      .CNT_W   (CNT_W),
      .PERSIST (PERSIST)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .block (mon_block[i]),
      .cnt   (cnt[i]),
      .hit   (hit[i])
    );
  end

  // Round-robin search: first pending index at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < N_MON; k++) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(N_MON)) scan = scan - (IDX_W+1)'(N_MON);
      if (!gnt_found && pending[scan[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    rpt_valid  = (state == PRESENT);
    handshake  = (state == PRESENT) && rpt_ready;
    clr_mask   = handshake ? (N_MON'(1) << rpt_idx) : '0;
    case (state)
      IDLE:    if (gnt_found) state_next = PRESENT;
      PRESENT: if (rpt_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new crossing is OR-ed in after the handshake clear, so a set on the same index wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      rr_ptr     <= '0;
      rpt_idx    <= '0;
      rpt_cycles <= '0;
      deadlock   <= 1'b0;
    end else if (clear) begin
      pending  <= '0;
      rr_ptr   <= '0;
      deadlock <= 1'b0;
    end else begin
      pending  <= (pending & ~clr_mask) | hit;
      deadlock <= deadlock | (|hit);
      if (state == IDLE && gnt_found) begin
        rpt_idx    <= gnt_idx;
        rpt_cycles <= cnt[gnt_idx];
      end
      if (handshake)
        rr_ptr <= (rpt_idx == IDX_W'(N_MON - 1)) ? '0 : rpt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_deadlock_report_arbiter.sv
// Randomised and directed bench for deadlock_report_arbiter against a
// cycle-level behavioural reference model.
module tb_deadlock_report_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 8;
  localparam int CMAX = 255;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         rpt_ready = 1'b0;
  logic [N-1:0] mon_block = '0;
  logic         rpt_valid;
  logic [1:0]   rpt_idx;
  logic [W-1:0] rpt_cycles;
  logic         deadlock;

  deadlock_report_arbiter #(.N_MON(N), .CNT_W(W), .PERSIST(P)) dut (
    .clock      (clock),
    .reset      (reset),
    .mon_block  (mon_block),
    .clear      (clear),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_idx    (rpt_idx),
    .rpt_cycles (rpt_cycles),
    .deadlock   (deadlock)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt [N];
  bit m_pend [N];
  bit m_dl, m_valid;
  int m_idx, m_cyc, m_rr;

  int rep_idx [$];
  int rep_cyc [$];
  int rep_step [$];
  int step_no;
  int first_valid;
  logic [N-1:0] rblk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_pend[i] = 1'b0;
    end
    m_dl = 1'b0; m_valid = 1'b0; m_idx = 0; m_cyc = 0; m_rr = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] blk, input bit clr, input bit rdy);
    int g;
    bit hs;
    bit hitv [N];
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_pend[i] = 1'b0;
      end
      m_dl = 1'b0; m_valid = 1'b0; m_rr = 0;
      return;
    end
    hs = m_valid && rdy;
    g  = -1;
    if (!m_valid)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) hitv[i] = blk[i] && (m_cnt[i] == P - 1);
    if (hs) begin
      m_pend[m_idx] = 1'b0;
      m_rr = (m_idx + 1) % N;
      m_valid = 1'b0;
    end else if (g >= 0) begin
      m_idx = g;
      m_cyc = m_cnt[g];
      m_valid = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (hitv[i]) begin
        m_pend[i] = 1'b1;
        m_dl = 1'b1;
      end
      m_cnt[i] = blk[i] ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX) : 0;
    end
  endfunction

  task automatic step(input logic [N-1:0] blk, input bit clr, input bit rdy);
    mon_block = blk;
    clear     = clr;
    rpt_ready = rdy;
    if (rpt_valid && rdy && !clr) begin
      rep_idx.push_back(int'(rpt_idx));
      rep_cyc.push_back(int'(rpt_cycles));
      rep_step.push_back(step_no);
    end
    @(posedge clock);
    step_no++;
    model_step(blk, clr, rdy);
    #1;
    check("rpt_valid", int'(rpt_valid), int'(m_valid));
    check("deadlock", int'(deadlock), int'(m_dl));
    if (m_valid) begin
      check("rpt_idx", int'(rpt_idx), m_idx);
      check("rpt_cycles", int'(rpt_cycles), m_cyc);
    end
    if (rpt_valid && first_valid < 0) first_valid = step_no;
  endtask

  task automatic fresh();
    step('0, 1'b1, 1'b0);
    rep_idx.delete(); rep_cyc.delete(); rep_step.delete();
    step_no = 0;
    first_valid = -1;
  endtask

  initial begin
    model_reset();
    step_no = 0;
    first_valid = -1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_valid", int'(rpt_valid), 0);
    check("reset_idx", int'(rpt_idx), 0);
    check("reset_cycles", int'(rpt_cycles), 0);
    check("reset_deadlock", int'(deadlock), 0);
    reset = 1'b0;

    // Single monitor episode
    rep_idx.delete(); rep_cyc.delete(); rep_step.delete();
    repeat (20) step(4'b0100, 1'b0, 1'b1);
    repeat (5) step('0, 1'b0, 1'b1);
    check("single_n", rep_idx.size(), 1);
    if (rep_idx.size() == 1) begin
      check("single_idx", rep_idx[0], 2);
      check("single_cyc", rep_cyc[0], 8);
    end
    check("single_dl", int'(deadlock), 1);
    check("single_latency", first_valid, 9);

    // Simultaneous episodes
    fresh();
    repeat (30) step(4'b1011, 1'b0, 1'b1);
    repeat (4) step('0, 1'b0, 1'b1);
    check("multi_n", rep_idx.size(), 3);
    if (rep_idx.size() == 3) begin
      check("multi_idx0", rep_idx[0], 0);
      check("multi_idx1", rep_idx[1], 1);
      check("multi_idx2", rep_idx[2], 3);
      check("multi_cyc0", rep_cyc[0], 8);
      check("multi_cyc1", rep_cyc[1], 10);
      check("multi_cyc2", rep_cyc[2], 12);
      check("multi_gap01", rep_step[1] - rep_step[0], 2);
      check("multi_gap12", rep_step[2] - rep_step[1], 2);
    end

    // Backpressure
    fresh();
    repeat (12) step(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b0, 1'b0);
      check("hold_valid", int'(rpt_valid), 1);
      check("hold_idx", int'(rpt_idx), 1);
      check("hold_cyc", int'(rpt_cycles), 8);
    end
    step('0, 1'b0, 1'b1);
    check("hold_accept_n", rep_idx.size(), 1);
    check("hold_after_valid", int'(rpt_valid), 0);

    // Saturation and re-arm
    fresh();
    repeat (300) step(4'b0001, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    repeat (8) step(4'b0001, 1'b0, 1'b1);
    repeat (4) step('0, 1'b0, 1'b1);
    check("sat_n", rep_idx.size(), 2);
    if (rep_idx.size() == 2) begin
      check("sat_idx1", rep_idx[1], 0);
      check("sat_cyc1", rep_cyc[1], 8);
    end

    // Clear during presentation
    fresh();
    repeat (10) step(4'b1010, 1'b0, 1'b0);
    check("clr_pre_valid", int'(rpt_valid), 1);
    check("clr_pre_idx", int'(rpt_idx), 1);
    step('0, 1'b1, 1'b1);
    check("clr_valid", int'(rpt_valid), 0);
    check("clr_dl", int'(deadlock), 0);
    repeat (20) step('0, 1'b0, 1'b1);
    check("clr_none", rep_idx.size(), 0);

    // Asynchronous reset mid-presentation
    fresh();
    repeat (10) step(4'b0100, 1'b0, 1'b0);
    check("rst_pre_valid", int'(rpt_valid), 1);
    #3;
    reset = 1'b1;
    mon_block = '0;
    #1;
    check("rst_valid", int'(rpt_valid), 0);
    check("rst_idx", int'(rpt_idx), 0);
    check("rst_cycles", int'(rpt_cycles), 0);
    check("rst_dl", int'(deadlock), 0);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) step('0, 1'b0, 1'b1);
    check("rst_none", rep_idx.size(), 0);

    // Randomised traffic against the model
    fresh();
    rblk = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) rblk[i] = ~rblk[i];
      step(rblk, ($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
